// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Single-port memory arbiter between instruction fetch and
//                data ports, with byte/halfword lane steering and strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        nrst,
    // instruction port
    input  logic        imem_ren,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_load,
    output logic        ihit,
    // data port
    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_store,
    input  logic [1:0]  dmem_width,
    output logic [31:0] dmem_load,
    output logic        dhit,
    output logic        dmem_err,
    // memory bus
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_store,
    output logic [3:0]  mem_strobe,
    input  logic [31:0] mem_load,
    input  logic        mem_ready
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_ifetch  = 2'd1;
    localparam logic [1:0] c_st_daccess = 2'd2;
    localparam logic [3:0] c_limit      = 4'(STARVE_LIMIT);

    logic [1:0]  r_state;
    logic [3:0]  r_starve_cnt;
    logic [1:0]  r_lane;
    logic [1:0]  r_width;
    logic        r_mis;
    logic        r_mis_done;
    logic        r_mem_ren;
    logic        r_mem_wen;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_store;
    logic [3:0]  r_mem_strobe;

    logic        w_dreq;
    logic        w_grant_i;
    logic        w_grant_d;
    logic [1:0]  w_lane;
    logic        w_mis;
    logic [31:0] w_store;
    logic [3:0]  w_strobe;
    logic [31:0] w_shifted;
    logic [31:0] w_load;
    logic        w_dhit_ok;
    logic        w_dhit_err;
    logic        w_unused;

    // Fetch addresses are word aligned; the low bits carry no information.
    assign w_unused = ^imem_addr[1:0];

    assign w_dreq    = dmem_ren | dmem_wen;
    assign w_grant_i = imem_ren & (~w_dreq | (r_starve_cnt == c_limit));
    assign w_grant_d = w_dreq & ~w_grant_i;
    assign w_lane    = dmem_addr[1:0];
    assign w_mis     = ((dmem_width == 2'b01) & dmem_addr[0]) |
                       (dmem_width[1] & (dmem_addr[1:0] != 2'b00));

    always_comb begin
        w_store  = dmem_store;
        w_strobe = 4'hF;
        case (dmem_width)
            2'b00: begin
                w_store  = {4{dmem_store[7:0]}};
                w_strobe = 4'b0001 << w_lane;
            end
            2'b01: begin
                w_store  = {2{dmem_store[15:0]}};
                w_strobe = 4'b0011 << w_lane;
            end
            default: begin
                w_store  = dmem_store;
                w_strobe = 4'hF;
            end
        endcase
    end

    assign w_shifted = mem_load >> {r_lane, 3'b000};

    always_comb begin
        w_load = w_shifted;
        case (r_width)
            2'b00:   w_load = {24'd0, w_shifted[7:0]};
            2'b01:   w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= c_st_idle;
            r_starve_cnt <= 4'd0;
            r_lane       <= 2'd0;
            r_width      <= 2'd0;
            r_mis        <= 1'b0;
            r_mis_done   <= 1'b0;
            r_mem_ren    <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_store  <= 32'd0;
            r_mem_strobe <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_grant_i) begin
                        r_state      <= c_st_ifetch;
                        r_mem_ren    <= 1'b1;
                        r_mem_addr   <= {imem_addr[31:2], 2'b00};
                        r_mem_strobe <= 4'hF;
                        r_starve_cnt <= 4'd0;
                    end else if (w_grant_d) begin
                        r_state      <= c_st_daccess;
                        r_lane       <= w_lane;
                        r_width      <= dmem_width;
                        r_mis        <= w_mis;
                        r_mis_done   <= 1'b0;
                        r_mem_ren    <= dmem_ren & ~w_mis;
                        r_mem_wen    <= dmem_wen & ~w_mis;
                        r_mem_addr   <= {dmem_addr[31:2], 2'b00};
                        r_mem_store  <= w_store;
                        r_mem_strobe <= w_mis ? 4'd0 : (dmem_wen ? w_strobe : 4'hF);
                        if (imem_ren && (r_starve_cnt != c_limit))
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                    end
                end
                c_st_ifetch: begin
                    if (mem_ready) begin
                        r_state      <= c_st_idle;
                        r_mem_ren    <= 1'b0;
                        r_mem_strobe <= 4'd0;
                    end
                end
                c_st_daccess: begin
                    // Misaligned accesses never touch the bus and report a
                    // cycle later, independent of mem_ready.
                    if (r_mis) begin
                        if (r_mis_done) begin
                            r_state    <= c_st_idle;
                            r_mis      <= 1'b0;
                            r_mis_done <= 1'b0;
                        end else begin
                            r_mis_done <= 1'b1;
                        end
                    end else if (mem_ready) begin
                        r_state      <= c_st_idle;
                        r_mem_ren    <= 1'b0;
                        r_mem_wen    <= 1'b0;
                        r_mem_strobe <= 4'd0;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
            if (!imem_ren)
                r_starve_cnt <= 4'd0;
        end
    end

    assign w_dhit_ok  = (r_state == c_st_daccess) & ~r_mis & mem_ready;
    assign w_dhit_err = (r_state == c_st_daccess) & r_mis & r_mis_done;

    assign ihit       = (r_state == c_st_ifetch) & mem_ready;
    assign imem_load  = ihit ? mem_load : 32'd0;
    assign dhit       = w_dhit_ok | w_dhit_err;
    assign dmem_err   = w_dhit_err;
    assign dmem_load  = w_dhit_ok ? w_load : 32'd0;

    assign mem_ren    = r_mem_ren;
    assign mem_wen    = r_mem_wen;
    assign mem_addr   = r_mem_addr;
    assign mem_store  = r_mem_store;
    assign mem_strobe = r_mem_strobe;

endmodule

`default_nettype wire
